// File: rtl/track_pkg.sv
// Shared types and constants for the barrier track scheduler.
//   track_state_e : IDLE / PLAY / OVER game phases
//   row_t         : one 8-lane barrier row
//   SCORE_MAX     : score saturation value
//   LEVEL_MAX     : level saturation value
package track_pkg;

    localparam int unsigned SCORE_W   = 10;
    localparam int unsigned LEVEL_W   = 3;
    localparam int unsigned SCORE_MAX = 1023;
    localparam int unsigned LEVEL_MAX = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } track_state_e;

    typedef logic [7:0] row_t;

    // Increment that sticks at SCORE_MAX.
    function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_W'(SCORE_MAX)) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Programmable scroll-rate divider.
//   clk, reset : clock, synchronous active-high reset
//   en_i       : advance the counter this cycle
//   clr_i      : synchronous clear (wins over en_i)
//   tc_i       : terminal count; counter wraps to 0 after reaching it
//   tick_o     : high while the counter sits at (or above) the terminal count
module tick_divider #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] tc_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q;

    // ">=" so a terminal count lowered mid-count wraps at once instead of rolling over.
    assign tick_o = (cnt_q >= tc_i);

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tick_o ? '0 : cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/track_scheduler.sv
// Barrier datapath sequencer for the cart game: paces scrolling, holds the
// ROWS x 8 barrier field, detects car/barrier collisions, keeps score and
// level, and drives the game-over freeze.
//   clk, reset : clock, synchronous active-high reset
//   start      : start / restart request (level sensitive)
//   levelSW    : starting level, loaded while idle
//   new_row    : next barrier row from the generator, taken on step
//   car        : one-hot car position on the bottom row
//   step       : one-cycle scroll pulse (suppressed by a same-cycle collision)
//   gg         : game over (registered)
//   level      : current level
//   score      : barriers passed, saturating
//   grid       : barrier field, row 0 in the low byte
// Optional feature: define TRACK_SPEEDUP_EN to halve the scroll period at
// levels 2, 4 and 6 (terminal count shifted right by level[2:1]).
module track_scheduler
    import track_pkg::*;
#(
    parameter int unsigned TICK_W   = 4,
    parameter int unsigned ROWS     = 8,
    parameter int unsigned LEVEL_UP = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        levelSW,
    input  logic [7:0]        new_row,
    input  logic [7:0]        car,
    output logic              step,
    output logic              gg,
    output logic [2:0]        level,
    output logic [9:0]        score,
    output logic [ROWS*8-1:0] grid
);

    localparam int unsigned GRID_W = ROWS * 8;
    localparam int unsigned PASS_W = $clog2(LEVEL_UP + 1);
    localparam logic [TICK_W-1:0] TC_BASE = '1;

    track_state_e        state_q;
    logic                gg_q;
    logic [LEVEL_W-1:0]  level_q;
    logic [SCORE_W-1:0]  score_q;
    logic [GRID_W-1:0]   grid_q;
    logic [PASS_W-1:0]   pass_q;

    logic [LEVEL_W-1:0]  level_d;
    logic [SCORE_W-1:0]  score_d;
    logic [PASS_W-1:0]   pass_d;
    logic [GRID_W-1:0]   grid_d;

    row_t                car_row_c;
    logic                collision_c;
    logic                run_c;
    logic                tick_c;
    logic                step_c;
    logic                div_clr_c;
    logic [TICK_W-1:0]   tc_c;

    // Bottom row is where the car lives; any overlap ends the game.
    assign car_row_c   = grid_q[GRID_W-8 +: 8];
    assign collision_c = |(car_row_c & car);

    // Collision freezes the divider and masks the step in the same cycle.
    assign run_c  = (state_q == PLAY) && !collision_c;
    assign step_c = run_c && tick_c;

    assign div_clr_c = (state_q == IDLE) || ((state_q == OVER) && start);

`ifdef TRACK_SPEEDUP_EN
    assign tc_c = TC_BASE >> level_q[2:1];
`else
    assign tc_c = TC_BASE;
`endif

    tick_divider #(
        .W (TICK_W)
    ) u_tick_divider (
        .clk    (clk),
        .reset  (reset),
        .en_i   (run_c),
        .clr_i  (div_clr_c),
        .tc_i   (tc_c),
        .tick_o (tick_c)
    );

    // Shift down one row: new row enters at row 0, bottom row falls off.
    assign grid_d = {grid_q[GRID_W-9:0], new_row};

    // Score / pass / level values to commit when a step discards a barrier row.
    always_comb begin
        score_d = score_q;
        pass_d  = pass_q;
        level_d = level_q;
        if (|car_row_c) begin
            score_d = score_sat_inc(score_q);
            if (pass_q == PASS_W'(LEVEL_UP - 1)) begin
                pass_d = '0;
                if (level_q != LEVEL_W'(LEVEL_MAX)) begin
                    level_d = level_q + LEVEL_W'(1);
                end
            end else begin
                pass_d = pass_q + PASS_W'(1);
            end
        end
    end

    // Game FSM with the field, score and level registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gg_q    <= 1'b0;
            level_q <= '0;
            score_q <= '0;
            grid_q  <= '0;
            pass_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    level_q <= levelSW;
                    score_q <= '0;
                    grid_q  <= '0;
                    pass_q  <= '0;
                    gg_q    <= 1'b0;
                    if (start) begin
                        state_q <= PLAY;
                    end
                end
                PLAY: begin
                    if (collision_c) begin
                        state_q <= OVER;
                        gg_q    <= 1'b1;
                    end else if (step_c) begin
                        grid_q  <= grid_d;
                        score_q <= score_d;
                        pass_q  <= pass_d;
                        level_q <= level_d;
                    end
                end
                OVER: begin
                    if (start) begin
                        state_q <= IDLE;
                        gg_q    <= 1'b0;
                        level_q <= levelSW;
                        score_q <= '0;
                        grid_q  <= '0;
                        pass_q  <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign step  = step_c;
    assign gg    = gg_q;
    assign level = level_q;
    assign score = score_q;
    assign grid  = grid_q;

endmodule
